// File: rtl/cpu_peripheral_bridge.sv
// Decodes synchronised CPU requests onto NUM_PERIPHERALS strobe/ack regions. Strobe comes one cycle after valid.
// Ready is a level held until valid drops. A timeout completes any access that is never acked. No backpressure beyond holding ready.
module cpu_peripheral_bridge #(
  parameter int          NUM_PERIPHERALS = 4,
  parameter int          TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] ERROR_READ_DATA = 32'h0000_0000
) (
  input  logic                          clk_2x,
  input  logic                          reset_n,
  input  logic                          cpu_mem_valid_2x,
  input  logic [23:0]                   cpu_address_2x,
  input  logic [3:0]                    cpu_wstrb_2x,
  input  logic [31:0]                   cpu_write_data_2x,
  output logic                          cpu_mem_ready,
  output logic [31:0]                   cpu_read_data,
  output logic [NUM_PERIPHERALS-1:0]    periph_select,
  output logic                          periph_read_en,
  output logic [3:0]                    periph_write_en,
  output logic [19:0]                   periph_address,
  output logic [31:0]                   periph_write_data,
  input  logic [32*NUM_PERIPHERALS-1:0] periph_read_data,
  input  logic [NUM_PERIPHERALS-1:0]    periph_ack,
  output logic                          bus_error,
  input  logic                          bus_error_clear
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [4:0] NP      = 5'(NUM_PERIPHERALS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                     r_state;
  logic [NUM_PERIPHERALS-1:0] r_sel;
  logic                       r_rd_en;
  logic [3:0]                 r_wr_en;
  logic [19:0]                r_addr;
  logic [31:0]                r_wdata;
  logic [31:0]                r_rdata;
  logic                       r_ready;
  logic                       r_err;
  logic [7:0]                 r_cnt;

  logic [3:0]                 w_region;
  logic                       w_mapped;
  logic [NUM_PERIPHERALS-1:0] w_sel_dec;
  logic                       w_ack;
  logic [31:0]                w_rdata;

  assign w_region = cpu_address_2x[23:20];
  assign w_mapped = ({1'b0, w_region} < NP);

  // Only the latched select qualifies acks and read data, so stray acks are masked.
  assign w_ack = |(periph_ack & r_sel);

  always_comb begin
    w_sel_dec = '0;
    w_rdata   = '0;
    for (int i = 0; i < NUM_PERIPHERALS; i++) begin
      w_sel_dec[i] = (w_region == 4'(i));
      if (r_sel[i]) w_rdata = w_rdata | periph_read_data[32*i +: 32];
    end
  end

  always_ff @(posedge clk_2x or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_rd_en <= 1'b0;
      r_wr_en <= 4'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 4'b0;
      // A set later in this block overrides the clear in the same cycle.
      if (bus_error_clear) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_mem_valid_2x) begin
            if (w_mapped) begin
              r_state <= S_ACCESS;
              r_sel   <= w_sel_dec;
              r_addr  <= cpu_address_2x[19:0];
              r_wdata <= cpu_write_data_2x;
              r_cnt   <= '0;
              r_rd_en <= (cpu_wstrb_2x == 4'b0);
              r_wr_en <= cpu_wstrb_2x;
            end else begin
              r_state <= S_DONE;
              r_rdata <= ERROR_READ_DATA;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (!cpu_mem_valid_2x) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
          end else if (w_ack) begin
            r_state <= S_DONE;
            r_rdata <= w_rdata;
            r_sel   <= '0;
            r_ready <= 1'b1;
          end else if (r_cnt == TO_LAST) begin
            r_state <= S_DONE;
            r_rdata <= ERROR_READ_DATA;
            r_sel   <= '0;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          // Holding here until valid drops keeps one ready edge per request.
          if (!cpu_mem_valid_2x) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_mem_ready     = r_ready;
  assign cpu_read_data     = r_rdata;
  assign periph_select     = r_sel;
  assign periph_read_en    = r_rd_en;
  assign periph_write_en   = r_wr_en;
  assign periph_address    = r_addr;
  assign periph_write_data = r_wdata;
  assign bus_error         = r_err;

endmodule

// File: tb/tb_cpu_peripheral_bridge.sv
// Directed bench for cpu_peripheral_bridge with 4 regions and an 8-cycle timeout.
module tb_cpu_peripheral_bridge;

  localparam int NP = 4;

  logic          clk_2x = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_mem_valid_2x = 1'b0;
  logic [23:0]   cpu_address_2x = '0;
  logic [3:0]    cpu_wstrb_2x = '0;
  logic [31:0]   cpu_write_data_2x = '0;
  logic          cpu_mem_ready;
  logic [31:0]   cpu_read_data;
  logic [NP-1:0] periph_select;
  logic          periph_read_en;
  logic [3:0]    periph_write_en;
  logic [19:0]   periph_address;
  logic [31:0]   periph_write_data;
  logic [32*NP-1:0] periph_read_data = '0;
  logic [NP-1:0] periph_ack = '0;
  logic          bus_error;
  logic          bus_error_clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  cpu_peripheral_bridge #(
    .NUM_PERIPHERALS(NP),
    .TIMEOUT_CYCLES (8),
    .ERROR_READ_DATA(32'h0000_0000)
  ) dut (
    .clk_2x           (clk_2x),
    .reset_n          (reset_n),
    .cpu_mem_valid_2x (cpu_mem_valid_2x),
    .cpu_address_2x   (cpu_address_2x),
    .cpu_wstrb_2x     (cpu_wstrb_2x),
    .cpu_write_data_2x(cpu_write_data_2x),
    .cpu_mem_ready    (cpu_mem_ready),
    .cpu_read_data    (cpu_read_data),
    .periph_select    (periph_select),
    .periph_read_en   (periph_read_en),
    .periph_write_en  (periph_write_en),
    .periph_address   (periph_address),
    .periph_write_data(periph_write_data),
    .periph_read_data (periph_read_data),
    .periph_ack       (periph_ack),
    .bus_error        (bus_error),
    .bus_error_clear  (bus_error_clear)
  );

  always #5 clk_2x = ~clk_2x;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are checked and inputs changed 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk_2x);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(cpu_mem_ready), 0);
    chk("rst_sel",   32'(periph_select), 0);
    chk("rst_rdata", cpu_read_data, 0);
    chk("rst_err",   32'(bus_error), 0);
    chk("rst_addr",  32'(periph_address), 0);
    chk("rst_wdata", periph_write_data, 0);
    @(negedge clk_2x);
    reset_n = 1'b1;
    tick();

    // Zero-wait read on region 1
    periph_read_data[63:32] = 32'hCAFE_F00D;
    periph_read_data[31:0]  = 32'h1111_2222;
    cpu_address_2x = 24'h10_0040; cpu_wstrb_2x = 4'b0; cpu_mem_valid_2x = 1'b1;
    tick();
    chk("zw_rd_en",  32'(periph_read_en), 1);
    chk("zw_wr_en",  32'(periph_write_en), 0);
    chk("zw_sel",    32'(periph_select), 32'h2);
    chk("zw_addr",   32'(periph_address), 32'h00040);
    chk("zw_rdy0",   32'(cpu_mem_ready), 0);
    periph_ack = 4'b0010;
    tick();
    periph_ack = 4'b0000;
    chk("zw_rdy1",   32'(cpu_mem_ready), 1);
    chk("zw_rdata",  cpu_read_data, 32'hCAFE_F00D);
    chk("zw_sel_clr", 32'(periph_select), 0);
    chk("zw_rd_en1", 32'(periph_read_en), 0);
    tick();
    chk("zw_rdy_hold", 32'(cpu_mem_ready), 1);
    cpu_mem_valid_2x = 1'b0;
    tick();
    chk("zw_rdy_fall", 32'(cpu_mem_ready), 0);

    // Byte write to region 0 with 3 wait states and a stray ack from region 2
    cpu_address_2x = 24'h00_0123; cpu_wstrb_2x = 4'b0010;
    cpu_write_data_2x = 32'h0000_AB00; cpu_mem_valid_2x = 1'b1;
    tick();
    chk("wr_wr_en",  32'(periph_write_en), 32'h2);
    chk("wr_rd_en",  32'(periph_read_en), 0);
    chk("wr_wdata",  periph_write_data, 32'h0000_AB00);
    chk("wr_sel1",   32'(periph_select), 32'h1);
    periph_ack = 4'b0100;
    tick();
    periph_ack = 4'b0000;
    chk("wr_wr_en2", 32'(periph_write_en), 0);
    chk("wr_sel2",   32'(periph_select), 32'h1);
    chk("wr_stray",  32'(cpu_mem_ready), 0);
    tick();
    chk("wr_sel3",   32'(periph_select), 32'h1);
    tick();
    chk("wr_sel4",   32'(periph_select), 32'h1);
    chk("wr_rdy_w",  32'(cpu_mem_ready), 0);
    periph_ack = 4'b0001;
    tick();
    periph_ack = 4'b0000;
    chk("wr_rdy",    32'(cpu_mem_ready), 1);
    chk("wr_rdata",  cpu_read_data, 32'h1111_2222);
    chk("wr_sel_clr", 32'(periph_select), 0);
    chk("wr_err",    32'(bus_error), 0);
    cpu_mem_valid_2x = 1'b0;
    tick();
    chk("wr_rdy_fall", 32'(cpu_mem_ready), 0);

    // Timeout on region 2 while the other regions keep acking
    cpu_address_2x = 24'h20_0010; cpu_wstrb_2x = 4'b0; cpu_mem_valid_2x = 1'b1;
    periph_ack = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_sel",  32'(periph_select), 32'h4);
      chk("to_rdy0", 32'(cpu_mem_ready), 0);
    end
    tick();
    chk("to_rdy",   32'(cpu_mem_ready), 1);
    chk("to_rdata", cpu_read_data, 32'h0);
    chk("to_err",   32'(bus_error), 1);
    chk("to_sel_clr", 32'(periph_select), 0);
    periph_ack = 4'b0000;
    cpu_mem_valid_2x = 1'b0; bus_error_clear = 1'b1;
    tick();
    bus_error_clear = 1'b0;
    chk("to_err_clr", 32'(bus_error), 0);
    chk("to_rdy_fall", 32'(cpu_mem_ready), 0);

    // Unmapped access with a simultaneous clear: the set must win
    cpu_address_2x = 24'hF0_0000; cpu_mem_valid_2x = 1'b1; bus_error_clear = 1'b1;
    tick();
    bus_error_clear = 1'b0;
    chk("um_rdy",   32'(cpu_mem_ready), 1);
    chk("um_sel",   32'(periph_select), 0);
    chk("um_rd_en", 32'(periph_read_en), 0);
    chk("um_err",   32'(bus_error), 1);
    chk("um_rdata", cpu_read_data, 32'h0);
    cpu_mem_valid_2x = 1'b0;
    tick();
    chk("um_rdy_fall", 32'(cpu_mem_ready), 0);
    chk("um_err_sticky", 32'(bus_error), 1);

    // Back-to-back on region 3: valid held across DONE must not retrigger
    periph_read_data[127:96] = 32'h3333_4444;
    cpu_address_2x = 24'h30_0008; cpu_mem_valid_2x = 1'b1;
    tick();
    chk("bb_rd_en1", 32'(periph_read_en), 1);
    periph_ack = 4'b1000;
    tick();
    chk("bb_rdy1",  32'(cpu_mem_ready), 1);
    chk("bb_rdata", cpu_read_data, 32'h3333_4444);
    tick();
    chk("bb_no_re", 32'(periph_read_en), 0);
    chk("bb_no_sel", 32'(periph_select), 0);
    chk("bb_hold",  32'(cpu_mem_ready), 1);
    cpu_mem_valid_2x = 1'b0;
    tick();
    chk("bb_rdy_fall", 32'(cpu_mem_ready), 0);
    cpu_mem_valid_2x = 1'b1;
    tick();
    chk("bb_rd_en2", 32'(periph_read_en), 1);
    chk("bb_sel2",   32'(periph_select), 32'h8);
    tick();
    chk("bb_rdy2",  32'(cpu_mem_ready), 1);
    periph_ack = 4'b0000; cpu_mem_valid_2x = 1'b0;
    tick();

    // Abort: valid dropped mid-ACCESS on region 1
    cpu_address_2x = 24'h10_0004; cpu_mem_valid_2x = 1'b1;
    tick();
    chk("ab_sel1", 32'(periph_select), 32'h2);
    tick();
    cpu_mem_valid_2x = 1'b0;
    tick();
    chk("ab_sel_clr", 32'(periph_select), 0);
    chk("ab_rdy",  32'(cpu_mem_ready), 0);
    tick();
    chk("ab_rdy2", 32'(cpu_mem_ready), 0);

    // Asynchronous reset in the middle of a write access
    cpu_address_2x = 24'h00_0200; cpu_wstrb_2x = 4'b1111;
    cpu_write_data_2x = 32'hDEAD_BEEF; cpu_mem_valid_2x = 1'b1;
    tick();
    chk("rs_wr_en", 32'(periph_write_en), 32'hF);
    reset_n = 1'b0;
    #1;
    chk("rs_sel",   32'(periph_select), 0);
    chk("rs_wr_en0", 32'(periph_write_en), 0);
    chk("rs_rdy",   32'(cpu_mem_ready), 0);
    chk("rs_err",   32'(bus_error), 0);
    chk("rs_wdata", periph_write_data, 0);
    reset_n = 1'b1; cpu_mem_valid_2x = 1'b0; cpu_wstrb_2x = 4'b0;
    tick();
    cpu_address_2x = 24'h10_0044; cpu_mem_valid_2x = 1'b1;
    tick();
    chk("rs_rd_en", 32'(periph_read_en), 1);
    chk("rs_addr",  32'(periph_address), 32'h00044);
    periph_ack = 4'b0010;
    tick();
    periph_ack = 4'b0000;
    chk("rs_rdy1",  32'(cpu_mem_ready), 1);
    chk("rs_rdata", cpu_read_data, 32'hCAFE_F00D);
    cpu_mem_valid_2x = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
